// File: rtl/mips_pkg.sv
// Opcode/funct encodings and instruction field positions shared by the
// pipeline control blocks.
package mips_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // True for every instruction that touches HI/LO.
    function automatic logic is_mdu(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               (funct == FN_MULT || funct == FN_MULTU || funct == FN_DIV  || funct == FN_DIVU ||
                funct == FN_MFHI || funct == FN_MFLO  || funct == FN_MTHI || funct == FN_MTLO);
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// MDU busy timer: reloads on a start according to the operation kind and
// counts down to zero; mdu_busy is high while the count is nonzero.
module mdu_timer
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    input  logic [5:0] funct,
    output logic       mdu_busy
);

    localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES);

    logic [4:0] count_reg;
    logic [4:0] count_next;
    logic [4:0] load_val;

    always_comb begin
        load_val = 5'd1;
        case (funct)
            FN_MULT, FN_MULTU: load_val = MULT_LD;
            FN_DIV,  FN_DIVU:  load_val = DIV_LD;
            default:           load_val = 5'd1;
        endcase
    end

    // A start always reloads, even over a running count.
    always_comb begin
        count_next = count_reg;
        if (start)
            count_next = load_val;
        else if (count_reg != 5'd0)
            count_next = count_reg - 5'd1;
    end

    always_ff @(posedge CLK) begin
        if (!Reset)
            count_reg <= 5'd0;
        else
            count_reg <= count_next;
    end

    assign mdu_busy = (count_reg != 5'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall scheduler for the five-stage pipeline (load-use and HI/LO).
// Define PIPE_CTRL_STATS_EN to add the saturating stall_cnt output.
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] IMcode_D,
    input  logic [31:0] IMcode_E,
    input  logic [31:0] IMcode_M,
    output logic        stall,
    output logic        flush_E,
    output logic        mdu_start,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        mdu_busy
);

    logic [5:0] op_d, funct_d, op_e, funct_e;
    logic [4:0] rs_d, rt_d, rt_e;
    logic       reads_rs_d, reads_rt_d, load_e;
    logic       load_use_haz, mdu_haz;

    assign op_d    = IMcode_D[OP_HI:OP_LO];
    assign funct_d = IMcode_D[FUNCT_HI:FUNCT_LO];
    assign rs_d    = IMcode_D[RS_HI:RS_LO];
    assign rt_d    = IMcode_D[RT_HI:RT_LO];
    assign op_e    = IMcode_E[OP_HI:OP_LO];
    assign funct_e = IMcode_E[FUNCT_HI:FUNCT_LO];
    assign rt_e    = IMcode_E[RT_HI:RT_LO];

    // Shifts by immediate take their operand from rt only.
    assign reads_rs_d = !(op_d == OP_J || op_d == OP_JAL || op_d == OP_LUI ||
                          (op_d == OP_RTYPE &&
                           (funct_d == FN_SLL || funct_d == FN_SRL || funct_d == FN_SRA)));
    assign reads_rt_d = (op_d == OP_RTYPE) || (op_d == OP_BEQ) || (op_d == OP_BNE) ||
                        (op_d == OP_SB) || (op_d == OP_SH) || (op_d == OP_SW);
    assign load_e     = (op_e == OP_LB) || (op_e == OP_LH) || (op_e == OP_LW) ||
                        (op_e == OP_LBU) || (op_e == OP_LHU);

    assign load_use_haz = load_e && (rt_e != 5'd0) &&
                          ((reads_rs_d && rs_d == rt_e) || (reads_rt_d && rt_d == rt_e));

    assign mdu_start = is_mdu(op_e, funct_e) && (funct_e != FN_MFHI) && (funct_e != FN_MFLO);
    assign mdu_haz   = is_mdu(op_d, funct_d) && (mdu_busy || mdu_start);

    assign stall   = load_use_haz || mdu_haz;
    assign flush_E = stall;

    mdu_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_timer (
        .CLK      (CLK),
        .Reset    (Reset),
        .start    (mdu_start),
        .funct    (funct_e),
        .mdu_busy (mdu_busy)
    );

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge CLK) begin
        if (!Reset)
            stall_cnt_reg <= 32'd0;
        else if (stall && stall_cnt_reg != 32'hFFFF_FFFF)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt = stall_cnt_reg;
`endif

    // M-stage word and the fields not needed for decode are kept for future use.
    logic unused_ok;
    assign unused_ok = ^{IMcode_M, IMcode_E[25:21], IMcode_E[15:6], IMcode_D[15:6]};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, hand-written timing
// sequences and randomized instruction streams against a cycle-number model.
module tb_pipe_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [31:0] NOP = 32'h0;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] d_in, e_in, m_in;
    logic        stall, flush_E, mdu_start, mdu_busy;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 CLK = ~CLK;

    pipe_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .IMcode_D  (d_in),
        .IMcode_E  (e_in),
        .IMcode_M  (m_in),
        .stall     (stall),
        .flush_E   (flush_E),
        .mdu_start (mdu_start),
`ifdef PIPE_CTRL_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .mdu_busy  (mdu_busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          busy_until = -1;   // last cycle in which the MDU is still busy
    logic [31:0] stat_model = 32'd0;
    logic        last_stall, last_flush, last_start, last_busy;

    function automatic logic [31:0] rinst(input int funct, input int rs, input int rt, input int rd, input int sh = 0);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
    endfunction

    function automatic logic [31:0] iinst(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic bit m_is_load(input logic [31:0] i);
        int op = int'(i[31:26]);
        return op inside {'h20, 'h21, 'h23, 'h24, 'h25};
    endfunction

    function automatic bit m_reads_rs(input logic [31:0] i);
        int op = int'(i[31:26]);
        int fn = int'(i[5:0]);
        if (op inside {'h02, 'h03, 'h0F}) return 1'b0;
        if (op == 0 && fn inside {'h00, 'h02, 'h03}) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_reads_rt(input logic [31:0] i);
        int op = int'(i[31:26]);
        return op inside {'h00, 'h04, 'h05, 'h28, 'h29, 'h2B};
    endfunction

    function automatic bit m_hilo(input logic [31:0] i);
        return i[31:26] == 6'd0 && int'(i[5:0]) inside {'h10, 'h11, 'h12, 'h13, 'h18, 'h19, 'h1A, 'h1B};
    endfunction

    // Number of busy cycles an instruction in E starts; 0 = no start.
    function automatic int m_start_len(input logic [31:0] i);
        int fn = int'(i[5:0]);
        if (!m_hilo(i)) return 0;
        if (fn inside {'h18, 'h19}) return MC;
        if (fn inside {'h1A, 'h1B}) return DC;
        if (fn inside {'h11, 'h13}) return 1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic rst, input logic [31:0] di, input logic [31:0] ei,
                        input logic [31:0] mi, input bit chk);
        bit exp_busy, exp_start, luse, mhaz, exp_stall;
        int slen;
        @(negedge CLK);
        Reset = rst; d_in = di; e_in = ei; m_in = mi;
        #1;
        exp_busy  = (cyc <= busy_until);
        slen      = m_start_len(ei);
        exp_start = (slen != 0);
        luse = m_is_load(ei) && ei[20:16] != 5'd0 &&
               ((m_reads_rs(di) && di[25:21] == ei[20:16]) || (m_reads_rt(di) && di[20:16] == ei[20:16]));
        mhaz = m_hilo(di) && (exp_busy || exp_start);
        exp_stall = luse || mhaz;
        if (chk) begin
            check("model_stall", stall, exp_stall);
            check("model_flush_E", flush_E, exp_stall);
            check("model_mdu_start", mdu_start, exp_start);
            check("model_mdu_busy", mdu_busy, exp_busy);
`ifdef PIPE_CTRL_STATS_EN
            check("model_stall_cnt", stall_cnt, stat_model);
`endif
        end
        last_stall = stall; last_flush = flush_E; last_start = mdu_start; last_busy = mdu_busy;
        if (!rst) begin
            busy_until = cyc;
            stat_model = 32'd0;
        end else begin
            if (exp_start) busy_until = cyc + slen;
            if (exp_stall && stat_model != 32'hFFFF_FFFF) stat_model = stat_model + 32'd1;
        end
        cyc++;
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] e;
        bit          stall;
        bit          start;
    } vec_t;

    function automatic logic [31:0] rand_instr();
        int r1 = $urandom_range(0, 3);
        int r2 = $urandom_range(0, 3);
        int r3 = $urandom_range(0, 3);
        case ($urandom_range(0, 15))
            0:  return iinst('h23, r1, r2, 0);
            1:  return iinst('h20 + $urandom_range(0, 1), r1, r2, 4);
            2:  return rinst('h20, r1, r2, r3);
            3:  return iinst('h2B, r1, r2, 0);
            4:  return iinst('h0F, r1, r2, 7);
            5:  return rinst('h00, r1, r2, r3, 3);
            6:  return {6'h02, 26'($urandom)};
            7:  return iinst('h04, r1, r2, 2);
            8:  return iinst('h08, r1, r2, 1);
            9:  return rinst('h18 + $urandom_range(0, 1), r1, r2, 0);
            10: return rinst('h1A + $urandom_range(0, 1), r1, r2, 0);
            11: return rinst('h11 + 2 * $urandom_range(0, 1), r1, 0, 0);
            12: return rinst('h10 + 2 * $urandom_range(0, 1), 0, 0, r3);
            13: return iinst('h24 + $urandom_range(0, 1), r1, r2, 0);
            default: return NOP;
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        logic [31:0] lw8, mfhi9, mult45, div45, addu, mflo9;
        int n_stall, n_busy;

        lw8    = iinst('h23, 0, 8, 0);
        mfhi9  = rinst('h10, 0, 0, 9);
        mflo9  = rinst('h12, 0, 0, 9);
        mult45 = rinst('h18, 4, 5, 0);
        div45  = rinst('h1A, 4, 5, 0);
        addu   = rinst('h21, 1, 2, 3);

        tbl.push_back('{"lw_add_rs",   rinst('h20, 8, 1, 9),     lw8,                    1'b1, 1'b0});
        tbl.push_back('{"lw_r0",       rinst('h20, 0, 0, 9),     iinst('h23, 0, 0, 0),   1'b0, 1'b0});
        tbl.push_back('{"lw_sw_rt",    iinst('h2B, 2, 8, 0),     lw8,                    1'b1, 1'b0});
        tbl.push_back('{"lw_lui",      iinst('h0F, 8, 8, 5),     lw8,                    1'b0, 1'b0});
        tbl.push_back('{"lw_sll_rs",   rinst('h00, 8, 1, 9, 2),  lw8,                    1'b0, 1'b0});
        tbl.push_back('{"lw_sll_rt",   rinst('h00, 0, 8, 9, 2),  lw8,                    1'b1, 1'b0});
        tbl.push_back('{"lw_j",        {6'h02, 5'd8, 5'd8, 16'd0}, lw8,                  1'b0, 1'b0});
        tbl.push_back('{"lb_addi_rs",  iinst('h08, 8, 9, 1),     iinst('h20, 0, 8, 0),   1'b1, 1'b0});
        tbl.push_back('{"lw_addi_rt",  iinst('h08, 1, 8, 1),     lw8,                    1'b0, 1'b0});
        tbl.push_back('{"lbu_beq_rt",  iinst('h04, 1, 8, 0),     iinst('h24, 0, 8, 0),   1'b1, 1'b0});
        tbl.push_back('{"lhu_bne_rs",  iinst('h05, 8, 1, 0),     iinst('h25, 0, 8, 0),   1'b1, 1'b0});
        tbl.push_back('{"lh_jal",      {6'h03, 5'd8, 5'd8, 16'd0}, iinst('h21, 0, 8, 0), 1'b0, 1'b0});
        tbl.push_back('{"addu_noload", rinst('h20, 8, 8, 9),     rinst('h21, 1, 8, 8),   1'b0, 1'b0});
        tbl.push_back('{"mult_mfhi",   mfhi9,                    mult45,                 1'b1, 1'b1});
        tbl.push_back('{"mfhi_in_e",   NOP,                      mfhi9,                  1'b0, 1'b0});
        tbl.push_back('{"mthi_mflo",   mflo9,                    rinst('h11, 4, 0, 0),   1'b1, 1'b1});
        tbl.push_back('{"divu_add",    rinst('h20, 1, 2, 3),     rinst('h1B, 4, 5, 0),   1'b0, 1'b1});
        tbl.push_back('{"lw_multd",    rinst('h18, 8, 1, 0),     lw8,                    1'b1, 1'b0});
        tbl.push_back('{"mtlo_nop",    NOP,                      rinst('h13, 4, 0, 0),   1'b0, 1'b1});

        step(1'b0, NOP, NOP, NOP, 1'b0);
        step(1'b0, NOP, NOP, NOP, 1'b1);
        check("reset_busy", last_busy, 1'b0);
        check("reset_stall", last_stall, 1'b0);

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].d, tbl[i].e, NOP, 1'b1);
            check({"tbl_stall_", tbl[i].name}, last_stall, tbl[i].stall);
            check({"tbl_flush_", tbl[i].name}, last_flush, tbl[i].stall);
            check({"tbl_start_", tbl[i].name}, last_start, tbl[i].start);
            step(1'b0, NOP, NOP, NOP, 1'b1);
        end

        // Load-use bubble clears the hazard after exactly one cycle.
        step(1'b1, rinst('h20, 8, 1, 9), lw8, NOP, 1'b1);
        check("lu_first", last_stall, 1'b1);
        step(1'b1, rinst('h20, 8, 1, 9), NOP, lw8, 1'b1);
        check("lu_second", last_stall, 1'b0);
        check("lu_second_flush", last_flush, 1'b0);

        // mult then dependent mfhi.
        step(1'b0, NOP, NOP, NOP, 1'b1);
        step(1'b1, mfhi9, mult45, NOP, 1'b1);
        check("mult_start", last_start, 1'b1);
        n_stall = int'(last_stall);
        n_busy  = int'(last_busy);
        for (int k = 1; k <= MC; k++) begin
            step(1'b1, mfhi9, NOP, NOP, 1'b1);
            check("mult_win_busy", last_busy, 1'b1);
            n_stall += int'(last_stall);
            n_busy  += int'(last_busy);
        end
        step(1'b1, mfhi9, NOP, NOP, 1'b1);
        check("mult_release_stall", last_stall, 1'b0);
        check("mult_release_busy", last_busy, 1'b0);
        check("mult_stall_cycles", n_stall, MC + 1);
        check("mult_busy_cycles", n_busy, MC);
`ifdef PIPE_CTRL_STATS_EN
        check("stats_after_mult", stall_cnt, MC + 1);
        step(1'b0, NOP, NOP, NOP, 1'b1);
        step(1'b1, NOP, NOP, NOP, 1'b1);
        check("stats_after_reset", stall_cnt, 32'd0);
`endif

        // div with unrelated addu in D: no stall, busy for DC cycles.
        step(1'b1, addu, div45, NOP, 1'b1);
        check("div_start", last_start, 1'b1);
        check("div_no_stall", last_stall, 1'b0);
        n_busy = 0;
        for (int k = 1; k <= DC; k++) begin
            step(1'b1, addu, NOP, NOP, 1'b1);
            n_busy += int'(last_busy);
            check("div_addu_no_stall", last_stall, 1'b0);
        end
        check("div_busy_cycles", n_busy, DC);
        step(1'b1, NOP, NOP, NOP, 1'b1);
        check("div_done", last_busy, 1'b0);

        // Reset in the third busy cycle of a div.
        step(1'b1, NOP, div45, NOP, 1'b1);
        step(1'b1, NOP, NOP, NOP, 1'b1);
        step(1'b1, NOP, NOP, NOP, 1'b1);
        step(1'b0, NOP, NOP, NOP, 1'b1);
        check("div_rst_still_busy", last_busy, 1'b1);
        step(1'b1, mflo9, NOP, NOP, 1'b1);
        check("div_rst_cleared", last_busy, 1'b0);
        check("div_rst_mflo_go", last_stall, 1'b0);

        // Randomized streams, M carries the previous E.
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] prev_e;
            prev_e = e_in;
            step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, rand_instr(), rand_instr(), prev_e, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
